// File: rtl/fab_term_pkg.sv
// Shared constants and helpers for fabric-edge terminating tiles.
// Mode encodings and flat config-bit addressing.
package fab_term_pkg;

  localparam logic [1:0] TERM_TIE0     = 2'd0;
  localparam logic [1:0] TERM_LOOP     = 2'd1;
  localparam logic [1:0] TERM_LOOP_REG = 2'd2;
  localparam logic [1:0] TERM_TIE1     = 2'd3;

  typedef struct packed {
    logic [15:0] frame;
    logic [15:0] bitpos;
  } cfg_idx_t;

  // Map a flat config bit number onto {frame, bit within frame}.
  function automatic cfg_idx_t cfg_bit_idx(input int k, input int row_bits);
    cfg_idx_t r;
    r.frame  = 16'(k / row_bits);
    r.bitpos = 16'(k % row_bits);
    return r;
  endfunction

endpackage

// File: rtl/term_cfg_frame_reg.sv
// Frame capture bank for a terminating tile.
// Writes every strobed frame; flags overlapping strobes.
module term_cfg_frame_reg
  import fab_term_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int NoConfigFrames  = 2
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [FrameBitsPerRow-1:0]                     frame_data,
  input  logic [NoConfigFrames-1:0]                      frame_strobe,
  output logic [NoConfigFrames-1:0][FrameBitsPerRow-1:0] cfg,
  output logic                                           cfg_err
);

  localparam logic [NoConfigFrames-1:0] ONE = NoConfigFrames'(1);

  logic multi;

  // More than one bit set iff clearing the lowest set bit leaves something.
  always_comb begin
    multi = |(frame_strobe & (frame_strobe - ONE));
  end

  // Capture bank: each strobed frame loads the row data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg <= '0;
    end else begin
      for (int f = 0; f < NoConfigFrames; f++) begin
        if (frame_strobe[f]) cfg[f] <= frame_data;
      end
    end
  end

  // Sticky overlap flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) cfg_err <= 1'b0;
    else if (multi) cfg_err <= 1'b1;
  end

endmodule

// File: rtl/term_tile_cfg_pipe.sv
// Fabric-edge terminating tile with retimed frame forwarding.
// Per-wire tie-off / loopback selected from captured config.
module term_tile_cfg_pipe
  import fab_term_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NoConfigFrames  = 2,
  parameter int NUM_WIRES       = 16,
  parameter int PIPE_STAGES     = 1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_WIRES-1:0]       N_END,
  output logic [NUM_WIRES-1:0]       S_BEG,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
  output logic                       cfg_err
);

  logic [NoConfigFrames-1:0][FrameBitsPerRow-1:0] cfg;
  logic [NUM_WIRES-1:0]                           loop_q;

  term_cfg_frame_reg #(
    .FrameBitsPerRow (FrameBitsPerRow),
    .NoConfigFrames  (NoConfigFrames)
  ) u_cfg (
    .clk          (CLK),
    .rst          (RESET),
    .frame_data   (FrameData),
    .frame_strobe (FrameStrobe[NoConfigFrames-1:0]),
    .cfg          (cfg),
    .cfg_err      (cfg_err)
  );

  generate
    if (PIPE_STAGES == 0) begin : g_wire
      assign FrameData_O   = FrameData;
      assign FrameStrobe_O = FrameStrobe;
    end else begin : g_pipe
      logic [FrameBitsPerRow-1:0] data_q [PIPE_STAGES];
      logic [MaxFramesPerCol-1:0] strb_q [PIPE_STAGES];

      // Shift register retiming the frame buses down the column.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          for (int i = 0; i < PIPE_STAGES; i++) begin
            data_q[i] <= '0;
            strb_q[i] <= '0;
          end
        end else begin
          data_q[0] <= FrameData;
          strb_q[0] <= FrameStrobe;
          for (int i = 1; i < PIPE_STAGES; i++) begin
            data_q[i] <= data_q[i-1];
            strb_q[i] <= strb_q[i-1];
          end
        end
      end

      assign FrameData_O   = data_q[PIPE_STAGES-1];
      assign FrameStrobe_O = strb_q[PIPE_STAGES-1];
    end
  endgenerate

  // Free-running loopback register so mode switches see no bubble.
  always_ff @(posedge CLK) begin
    if (RESET) loop_q <= '0;
    else loop_q <= N_END;
  end

  for (genvar w = 0; w < NUM_WIRES; w++) begin : g_wire_mux
    localparam cfg_idx_t LO = cfg_bit_idx(2 * w, FrameBitsPerRow);
    localparam cfg_idx_t HI = cfg_bit_idx(2 * w + 1, FrameBitsPerRow);
    localparam int LO_F = int'(LO.frame);
    localparam int LO_B = int'(LO.bitpos);
    localparam int HI_F = int'(HI.frame);
    localparam int HI_B = int'(HI.bitpos);

    logic [1:0] mode;
    logic       sel;

    assign mode = {cfg[HI_F][HI_B], cfg[LO_F][LO_B]};

    // Per-wire termination mode select.
    always_comb begin
      sel = 1'b0;
      unique case (mode)
        TERM_TIE0:     sel = 1'b0;
        TERM_LOOP:     sel = N_END[w];
        TERM_LOOP_REG: sel = loop_q[w];
        TERM_TIE1:     sel = 1'b1;
        default:       sel = 1'b0;
      endcase
    end

    assign S_BEG[w] = sel;
  end

endmodule
